// File: rtl/ycbcr_pkg.sv
// Shared types and constants for the YCbCr->RGB stream scheduler.
package ycbcr_pkg;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_pix_t;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
  } rgb_fx_t;

  localparam ycc_pix_t YCC_BUBBLE = 24'h008080;

  typedef enum logic [1:0] {
    PH_Y  = 2'd0,
    PH_CB = 2'd1,
    PH_CR = 2'd2
  } ph_e;

endpackage

// File: rtl/ycbcr_rgb_fifo.sv
// First-word-fall-through result FIFO; head reads as zero while empty.
module ycbcr_rgb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_wr    = i_push && (!w_full || i_pop);
  assign w_rd    = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rp];
  assign o_count = r_count;

endmodule

// File: rtl/ycbcr_rgb_sched.sv
// Feeds whole pixels into the byte-serial ycbcr_rgb converter's 3-cycle slots and
// buffers real results; optional counters under YCBCR_SCHED_STATS_EN.
module ycbcr_rgb_sched
  import ycbcr_pkg::*;
#(
  parameter int unsigned CONV_LAT   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_data,
  output logic        conv_reset,
  output logic [7:0]  conv_in_data,
  input  logic [15:0] conv_r,
  input  logic [15:0] conv_g,
  input  logic [15:0] conv_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic [15:0] out_g,
  output logic [15:0] out_b
`ifdef YCBCR_SCHED_STATS_EN
  ,
  output logic [15:0] stat_in_cnt,
  output logic [15:0] stat_out_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  ph_e                 r_ph;
  ph_e                 w_ph_nxt;
  ycc_pix_t            r_slot;
  logic                r_slot_real;
  logic [CW-1:0]       r_credits;
  logic [CONV_LAT-1:0] r_tag;
  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  rgb_fx_t             w_head;
  logic [AW:0]         w_count;

  assign conv_reset = ~reset;

  always_ff @(posedge clk) begin
    if (!reset) r_ph <= PH_Y;
    else        r_ph <= w_ph_nxt;
  end

  always_comb begin
    w_ph_nxt = PH_Y;
    case (r_ph)
      PH_Y:    w_ph_nxt = PH_CB;
      PH_CB:   w_ph_nxt = PH_CR;
      default: w_ph_nxt = PH_Y;
    endcase
  end

  assign pix_ready = (r_ph == PH_CR) && (r_credits != '0);
  assign w_accept  = pix_valid && pix_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_slot      <= YCC_BUBBLE;
      r_slot_real <= 1'b0;
    end else if (r_ph == PH_CR) begin
      r_slot      <= w_accept ? ycc_pix_t'(pix_data) : YCC_BUBBLE;
      r_slot_real <= w_accept;
    end
  end

  always_comb begin
    conv_in_data = r_slot.cr;
    case (r_ph)
      PH_Y:    conv_in_data = r_slot.y;
      PH_CB:   conv_in_data = r_slot.cb;
      default: conv_in_data = r_slot.cr;
    endcase
  end

  // Credits cover both in-flight real slots and FIFO occupancy, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credits <= CW'(FIFO_DEPTH);
    end else if (w_accept && !w_pop) begin
      r_credits <= r_credits - CW'(1);
    end else if (!w_accept && w_pop) begin
      r_credits <= r_credits + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_tag <= '0;
    else        r_tag <= {r_tag[CONV_LAT-2:0], (r_ph == PH_Y) && r_slot_real};
  end

  assign w_push = r_tag[CONV_LAT-1];

  ycbcr_rgb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (48)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  ({conv_r, conv_g, conv_b}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign out_valid = (w_count != '0);
  assign out_r     = w_head.r;
  assign out_g     = w_head.g;
  assign out_b     = w_head.b;

`ifdef YCBCR_SCHED_STATS_EN
  logic [15:0] r_stat_in;
  logic [15:0] r_stat_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_in  <= '0;
      r_stat_out <= '0;
    end else begin
      if (w_accept) r_stat_in  <= r_stat_in + 16'd1;
      if (w_pop)    r_stat_out <= r_stat_out + 16'd1;
    end
  end

  assign stat_in_cnt  = r_stat_in;
  assign stat_out_cnt = r_stat_out;
`endif

endmodule

// File: tb/tb_ycbcr_rgb_sched.sv
// Randomized bench for ycbcr_rgb_sched with a stand-in byte-serial converter and a queue model.
module tb_ycbcr_rgb_sched;

  localparam int unsigned CONV_LAT   = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [23:0] BUBBLE     = 24'h008080;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [23:0] pix_data = '0;
  logic        conv_reset;
  logic [7:0]  conv_in_data;
  logic [15:0] conv_r, conv_g, conv_b;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_r, out_g, out_b;
`ifdef YCBCR_SCHED_STATS_EN
  logic [15:0] stat_in_cnt, stat_out_cnt;
`endif

  always #5 clk = ~clk;

  ycbcr_rgb_sched #(
    .CONV_LAT   (CONV_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .conv_reset   (conv_reset),
    .conv_in_data (conv_in_data),
    .conv_r       (conv_r),
    .conv_g       (conv_g),
    .conv_b       (conv_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_r        (out_r),
    .out_g        (out_g),
    .out_b        (out_b)
`ifdef YCBCR_SCHED_STATS_EN
    ,
    .stat_in_cnt  (stat_in_cnt),
    .stat_out_cnt (stat_out_cnt)
`endif
  );

  // Stand-in converter: result for a slot whose Y byte was on the bus CONV_LAT cycles ago.
  logic [7:0] h [4];
  always @(posedge clk) begin
    if (conv_reset) begin
      for (int i = 0; i < 4; i++) h[i] <= 8'h00;
    end else begin
      h[0] <= conv_in_data;
      for (int i = 1; i < 4; i++) h[i] <= h[i-1];
    end
  end
  assign conv_r = {h[3], h[2]};
  assign conv_g = {h[2], h[1]};
  assign conv_b = {h[1], h[3]};

  int total = 0;
  int bad   = 0;
  int now   = 0;

  logic [23:0] q  [$];
  int          tq [$];
  int          m_ph    = 0;
  logic [23:0] m_slot  = BUBBLE;
  bit          m_known = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, now);
    end
  endfunction

  function automatic logic [7:0] slot_byte(input logic [23:0] p, input int ph);
    if (ph == 0) return p[23:16];
    if (ph == 1) return p[15:8];
    return p[7:0];
  endfunction

  function automatic logic [47:0] exp_rgb(input logic [23:0] p);
    return {p[23:16], p[15:8], p[15:8], p[7:0], p[7:0], p[23:16]};
  endfunction

  // Checks the current cycle against the model, drives inputs, advances one clock.
  task automatic step(input bit pv, input logic [23:0] pd, input bit ordy, input bit rn);
    bit e_rdy;
    bit e_vld;
    bit acc;
    bit pop;
    e_rdy = 1'b0;
    e_vld = 1'b0;
    if (m_known) begin
      e_rdy = (m_ph == 2) && (q.size() < FIFO_DEPTH);
      e_vld = (q.size() > 0) && (tq[0] <= now);
      chk("pix_ready", 64'(pix_ready), 64'(e_rdy));
      chk("out_valid", 64'(out_valid), 64'(e_vld));
      chk("conv_in_data", 64'(conv_in_data), 64'(slot_byte(m_slot, m_ph)));
      if (e_vld) chk("out_rgb", 64'({out_r, out_g, out_b}), 64'(exp_rgb(q[0])));
    end
    pix_valid = pv;
    pix_data  = pd;
    out_ready = ordy;
    reset     = rn;
    if (!rn) begin
      q.delete();
      tq.delete();
      m_ph    = 0;
      m_slot  = BUBBLE;
      m_known = 1'b1;
    end else if (m_known) begin
      acc = pv && e_rdy;
      pop = e_vld && ordy;
      if (pop) begin
        void'(q.pop_front());
        void'(tq.pop_front());
      end
      if (acc) begin
        q.push_back(pd);
        tq.push_back(now + CONV_LAT + 2);
      end
      if (m_ph == 2) m_slot = acc ? pd : BUBBLE;
      m_ph = (m_ph + 1) % 3;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  initial begin
    int  dut_acc;
    bit  did_rst;

    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_conv_in", 64'(conv_in_data), 64'h00);
    chk("rst_out_rgb", 64'({out_r, out_g, out_b}), 64'd0);
    chk("rst_conv_reset_held", 64'(conv_reset), 64'd1);

    for (int i = 0; i < 30; i++) begin
      chk("idle_byte", 64'(conv_in_data), (i % 3 == 0) ? 64'h00 : 64'h80);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      step(0, '0, 1, 1);
    end
    chk("run_conv_reset", 64'(conv_reset), 64'd0);

    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    chk("single_ready", 64'(pix_ready), 64'd1);
    step(1, 24'h808080, 1, 1);
    for (int k = 1; k < 6; k++) begin
      chk("single_early_valid", 64'(out_valid), 64'd0);
      step(0, '0, 1, 1);
    end
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_r", 64'(out_r), 64'h8080);
    chk("single_g", 64'(out_g), 64'h8080);
    chk("single_b", 64'(out_b), 64'h8080);
    step(0, '0, 1, 1);
    chk("single_once", 64'(out_valid), 64'd0);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 1);

    dut_acc = 0;
    for (int i = 0; i < 60; i++) begin
      if (pix_ready) dut_acc++;
      step(1, 24'($urandom), 1, 1);
    end
    chk("b2b_accepts", 64'(dut_acc), 64'd20);
    for (int i = 0; i < 12; i++) step(0, '0, 1, 1);

    dut_acc = 0;
    for (int i = 0; i < 30; i++) begin
      if (pix_ready) dut_acc++;
      step(1, 24'($urandom), 0, 1);
    end
    chk("full_accepts", 64'(dut_acc), 64'(FIFO_DEPTH));
    chk("full_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 40; i++) step(1, 24'($urandom), 1, 1);
    for (int i = 0; i < 12; i++) step(0, '0, 1, 1);

    did_rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!did_rst && i > 200 && q.size() >= 3) begin
        step(1, 24'($urandom), 0, 0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_pix_ready", 64'(pix_ready), 64'd0);
        chk("midrst_conv_in", 64'(conv_in_data), 64'h00);
        did_rst = 1'b1;
      end else begin
        step(($urandom % 4) != 0, 24'($urandom), ($urandom % 3) != 0, 1);
      end
    end
    chk("midrst_hit", 64'(did_rst), 64'd1);
    for (int i = 0; i < 20; i++) step(0, '0, 1, 1);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ycbcr_rgb_sched.md
# ycbcr_rgb_sched

Stream controller that owns the byte-serial `ycbcr_rgb` converter. It accepts whole {Y,Cb,Cr} pixels over a valid/ready handshake and serializes them into the converter's fixed 3-cycle byte slots. It inserts black bubble slots when no pixel is pending, tracks which converter results are real, and buffers them in a small output FIFO. Back-pressure on the output is converted into input back-pressure through a credit count, because the converter itself cannot stall.

## Interface
- `CONV_LAT`, 4: cycles from the Y-byte cycle of a slot to the first cycle that slot's R/G/B is valid on the converter outputs.
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `pix_valid`  in  1  input pixel present.
- `pix_ready`  out  1  controller accepts pixel this cycle.
- `pix_data`  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}, unsigned.
- `conv_reset`  out  1  active-high reset to converter, = ~reset (combinational).
- `conv_in_data`  out  8  byte to converter `in_data`.
- `conv_r`, `conv_g`, `conv_b`  in  16 each  converter results, 8.8 unsigned fixed point.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `out_r`, `out_g`, `out_b`  out  16 each  FIFO head.

## Operation
- Free-running phase counter `ph` ∈ {0,1,2}; `ph`=0 on the first cycle after reset deasserts, then 0→1→2→0. The converter is reset in the same cycles, so slot phases stay aligned.
- Slot byte on `conv_in_data`:
  - `ph`0: Y
  - `ph`1: Cb
  - `ph`2: Cr
  - Bytes come from the slot register `slot_pix`.
- `pix_ready` = (`ph`==2) && (`credits` > 0). A handshake loads `slot_pix` and sets `slot_real`=1. Otherwise, at `ph`==2, `slot_pix` loads bubble {0x00,0x80,0x80} with `slot_real`=0. The loaded slot starts at the next `ph`0.
- Tag pipe: a CONV_LAT-deep shift register, shifted every cycle. It inserts `slot_real` at `ph`0 and inserts 0 otherwise. When a 1 exits, {conv_r,conv_g,conv_b} is pushed into the FIFO in that same cycle.
- Credits:
  - `credits` = FIFO_DEPTH − (real slots in flight, i.e. accepted and not yet pushed) − FIFO occupancy.
  - Accept decrements; pop increments; accept and pop in the same cycle leave it unchanged.
  - FIFO overflow is therefore impossible.
- FIFO: in-order, first-word output. Push and pop in the same cycle while full or empty-with-push are both legal. Occupancy is unchanged when full. When empty, the pushed data appears on `out_*` the next cycle.
- Reset mid-operation: all in-flight pixels and FIFO contents are discarded, with no partial output.

## Timing
- Reset values:
  - `pix_ready`=0, `conv_in_data`=0x00, `out_valid`=0, `out_r/g/b`=0.
  - `credits`=FIFO_DEPTH, `ph`=0, tag pipe cleared, `slot_pix`=bubble.
- Slot 0 after reset is always a bubble.
- Latency:
  - Accept (`ph`2 cycle) to Y byte: 1 cycle.
  - Y byte to FIFO push: CONV_LAT cycles.
  - Push to `out_valid`: 1 cycle.
  - Total accept to `out_valid`: CONV_LAT+2 = 6 cycles by default.
- Peak throughput: 1 pixel per 3 cycles.
- `pix_data` is sampled only on a handshake. `out_*` are stable while `out_valid` && !`out_ready`.

## Configuration
- `YCBCR_SCHED_STATS_EN`: when defined, two extra outputs are added:
  - `stat_in_cnt` [15:0]: accepted pixels.
  - `stat_out_cnt` [15:0]: popped pixels.
  - Both wrap modulo 2^16 and are cleared by reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package `ycbcr_pkg`:
  - Pixel typedef `ycc_pix_t` (24 b).
  - Result typedef `rgb_fx_t` (3×16 b).
  - Bubble constant `YCC_BUBBLE` = 24'h008080.
  - Phase constants `PH_Y/PH_CB/PH_CR`.
- One sub-module `ycbcr_rgb_fifo` (parameterized depth, width 48, count output).
- The phase counter, tag pipe and credits stay in the top.

## Test plan
- Single pixel 0x808080, `out_ready`=1 → one output with R=G=B=0x8000 ±0x7F, `out_valid` 6 cycles after accept; no other output.
- 20 back-to-back pixels from `hw2_in.dat`, `out_ready`=1 → 20 outputs in order matching `hw2_out.dat` within 0x7F, spaced 3 cycles.
- `out_ready`=0, continuous `pix_valid` → exactly FIFO_DEPTH accepts, then `pix_ready` stays 0. Release `out_ready` → all 4 drain in order, accepts resume; no loss or duplication.
- `pix_valid`=0 for 30 cycles → `conv_in_data` cycles 00,80,80 and `out_valid` never asserts.
- FIFO full with `out_ready`=1 and a push in the same cycle → occupancy stays 4 and order is preserved.
- `reset`=0 for 1 cycle with 2 pixels in flight and 2 in FIFO → next cycle `out_valid`=0, `credits`=4, `ph`=0, and no stale output afterwards.
